hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Sequences the pipeline-register enables and clears (IF/ID, ID/EX, EX/MEM, MEM/WB) of the
//  5-stage RISC-V core. Detects load-use hazards, taken-branch flushes, multi-cycle mul/div
//  occupancy of EX, and data-memory wait states; drives Stall*/Flush* (Stall* feed register
//  en inverted, Flush* feed clr). Also provides performance counters and a memory-timeout flag.
// PARAMETERS
//  MD_LATENCY   4      total cycles a mul/div op occupies EX (legal range >=2)
//  MEM_TIMEOUT  256    consecutive dmem wait cycles that set mem_timeout
//  CNT_W        32     width of the performance counters
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  Rs1D, Rs2D   in   5      source register indices of the instruction in ID
//  RdE          in   5      destination index of the instruction in EX
//  ResultSrcE0  in   1      1 = instruction in EX is a load
//  PCSrcE       in   1      1 = branch/jump taken, resolved in EX
//  md_start_e   in   1      1 = instruction in EX is mul/div
//  mem_req_m    in   1      1 = load/store in MEM
//  dmem_ready   in   1      data memory completes the access this cycle
//  StallF       out  1      hold PC
//  StallD       out  1      hold IF/ID
//  StallE       out  1      hold ID/EX
//  StallM       out  1      hold EX/MEM
//  FlushD       out  1      clear IF/ID
//  FlushE       out  1      clear ID/EX
//  FlushM       out  1      clear EX/MEM (bubble behind stalled EX)
//  FlushW       out  1      clear MEM/WB (bubble behind stalled MEM)
//  md_done      out  1      1-cycle pulse: mul/div leaves EX this cycle
//  mem_timeout  out  1      sticky error; cleared only by reset
//  stall_cnt    out  CNT_W  cycles with StallF=1, saturating
//  flush_cnt    out  CNT_W  cycles with FlushD=1, saturating
// BEHAVIOUR
//  Reset (rst_n=0): state=RUN, md counter=0, wait counter=0, mem_timeout=0, stall_cnt=0,
//   flush_cnt=0; all Stall*/Flush*/md_done forced 0 while rst_n=0.
//  memwait = mem_req_m & ~dmem_ready (combinational, same cycle).
//  lwStall = ResultSrcE0 & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D) & ~PCSrcE.
//  States: RUN, MD_WAIT (MEM_WAIT is not a state; memwait overrides in every state).
//  Priority (highest first): memwait > mul/div hold > PCSrcE > lwStall.
//  memwait, any state: StallF=StallD=StallE=StallM=1, FlushW=1, all other Flush*=0.
//   PCSrcE, lwStall and md_start_e are ignored. State does not change, except MD_WAIT's
//   counter still decrements down to 1 and holds there.
//  RUN, no memwait:
//   md_start_e=1 -> StallF=StallD=StallE=1, FlushM=1; load cnt=MD_LATENCY-1; ->MD_WAIT.
//   else PCSrcE=1 -> FlushD=1, FlushE=1; no stalls.
//   else lwStall=1 -> StallF=StallD=1, FlushE=1 (single cycle; recomputed next cycle).
//  MD_WAIT, no memwait:
//   cnt>1 -> StallF=StallD=StallE=1, FlushM=1, cnt<=cnt-1.
//   cnt==1 -> no stall; md_done=1; ->RUN. PCSrcE/lwStall are evaluated as in RUN this cycle.
//    md_start_e is not re-evaluated this cycle.
//  Net effect: a mul/div sits MD_LATENCY cycles in EX and advances on the last of them,
//   plus any memwait cycles.
//  Wait counter: increments on each memwait cycle, clears on any cycle without memwait,
//   saturates at MEM_TIMEOUT. Reaching MEM_TIMEOUT sets mem_timeout=1 (sticky).
//  Counters: stall_cnt +1 when StallF=1; flush_cnt +1 when FlushD=1; both hold at all-ones.
//  Reset mid-MD_WAIT: returns to RUN at once; no md_done.
// TESTING
//  T1 lw x5 in EX, Rs1D=5, PCSrcE=0 -> 1 cycle StallF=StallD=FlushE=1; next cycle all 0.
//  T2 RdE=0 load, Rs1D=0 -> no stall. Load-use and PCSrcE=1 together -> FlushD=FlushE=1, StallF=0.
//  T3 md_start_e=1 in RUN, MD_LATENCY=4 -> StallE=1 for 3 cycles, md_done on cycle 4, RUN.
//  T4 memwait 5 cycles during MD_WAIT -> all four Stall* and FlushW=1 throughout; md_done
//     delayed until the first cycle with dmem_ready=1 and cnt==1.
//  T5 MEM_TIMEOUT=8, dmem_ready=0 for 8 cycles -> mem_timeout=1, stays 1 after ready returns.
//  T6 rst_n=0 during MD_WAIT cnt=2 -> all outputs 0 immediately; after release, state RUN,
//     counters 0.

Source files
------------

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_controller
//  Description : Pipeline stall/flush sequencer for the 5-stage RISC-V core.
//                Resolves load-use hazards, taken-branch flushes, multi-cycle
//                mul/div occupancy of EX and data-memory wait states, and
//                keeps saturating stall/flush counters plus a sticky
//                memory-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_controller #(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             md_start_e,
  input  logic             mem_req_m,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             md_done,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The mul/div counter only ever holds MD_LATENCY-1 down to 1.
  localparam int c_MD_W   = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [c_MD_W-1:0]   c_MD_LOAD  = c_MD_W'(MD_LATENCY - 1);
  localparam logic [c_MD_W-1:0]   c_MD_ONE   = c_MD_W'(1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_MD_W-1:0]   r_md_cnt;
  logic [c_MD_W-1:0]   w_md_cnt_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
  logic                r_mem_timeout;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic w_memwait;
  logic w_lw_stall;
  logic w_md_hold;

  // Unqualified control decisions; gated with rst_n before leaving the block.
  logic w_stall_f;
  logic w_stall_d;
  logic w_stall_e;
  logic w_stall_m;
  logic w_flush_d;
  logic w_flush_e;
  logic w_flush_m;
  logic w_flush_w;
  logic w_md_done;

  assign w_memwait  = mem_req_m & ~dmem_ready;
  assign w_lw_stall = ResultSrcE0 & (RdE != 5'd0) &
                      ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;
  // A mul/div still has more than its final cycle to spend in EX.
  assign w_md_hold  = (r_state == ST_MD_WAIT) && (r_md_cnt > c_MD_ONE);

  // State register and mul/div occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Next-state and stall/flush decode, priority memwait > mul/div > branch > load-use.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_stall_m    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_flush_m    = 1'b0;
    w_flush_w    = 1'b0;
    w_md_done    = 1'b0;

    if (w_memwait) begin
      // Freeze everything up to MEM and bubble WB. A running mul/div keeps
      // counting so the memory stall overlaps its latency, but it cannot
      // leave EX until the stall is gone, so the count parks at 1.
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
      if (w_md_hold) begin
        w_md_cnt_nxt = r_md_cnt - c_MD_ONE;
      end
    end else if (w_md_hold) begin
      w_stall_f    = 1'b1;
      w_stall_d    = 1'b1;
      w_stall_e    = 1'b1;
      w_flush_m    = 1'b1;
      w_md_cnt_nxt = r_md_cnt - c_MD_ONE;
    end else begin
      if (r_state == ST_MD_WAIT) begin
        // Final mul/div cycle: it advances now and the front end behaves as
        // in RUN. The op itself is still in EX, so md_start_e is not looked at.
        w_md_done   = 1'b1;
        w_state_nxt = ST_RUN;
      end

      if ((r_state == ST_RUN) && md_start_e) begin
        w_stall_f    = 1'b1;
        w_stall_d    = 1'b1;
        w_stall_e    = 1'b1;
        w_flush_m    = 1'b1;
        w_md_cnt_nxt = c_MD_LOAD;
        w_state_nxt  = ST_MD_WAIT;
      end else if (PCSrcE) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_lw_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  // Consecutive memwait cycles, saturating at the timeout threshold.
  always_comb begin
    w_wait_cnt_nxt = '0;
    if (w_memwait) begin
      if (r_wait_cnt == c_WAIT_MAX) begin
        w_wait_cnt_nxt = r_wait_cnt;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + c_WAIT_ONE;
      end
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Sticky timeout flag, set on the edge where the wait count hits the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_timeout <= 1'b0;
    end else if (w_wait_cnt_nxt == c_WAIT_MAX) begin
      r_mem_timeout <= 1'b1;
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_f && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
    end
  end

  // Saturating count of IF/ID flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
    end else if (w_flush_d && (r_flush_cnt != c_CNT_MAX)) begin
      r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
    end
  end

  // Control outputs are held low for the whole time reset is asserted.
  assign StallF      = rst_n & w_stall_f;
  assign StallD      = rst_n & w_stall_d;
  assign StallE      = rst_n & w_stall_e;
  assign StallM      = rst_n & w_stall_m;
  assign FlushD      = rst_n & w_flush_d;
  assign FlushE      = rst_n & w_flush_e;
  assign FlushM      = rst_n & w_flush_m;
  assign FlushW      = rst_n & w_flush_w;
  assign md_done     = rst_n & w_md_done;
  assign mem_timeout = r_mem_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_controller
//  Description : Self-checking bench for hazard_stall_controller with a
//                cycle-level reference model (mul/div tracked by elapsed age).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_controller;

  localparam int MD_LATENCY  = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 5;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       Rs1D, Rs2D, RdE;
  logic             ResultSrcE0, PCSrcE, md_start_e, mem_req_m, dmem_ready;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushM, FlushW;
  logic             md_done, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_stall_controller #(
    .MD_LATENCY (MD_LATENCY),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdE        (RdE),
    .ResultSrcE0(ResultSrcE0),
    .PCSrcE     (PCSrcE),
    .md_start_e (md_start_e),
    .mem_req_m  (mem_req_m),
    .dmem_ready (dmem_ready),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .FlushW     (FlushW),
    .md_done    (md_done),
    .mem_timeout(mem_timeout),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: StallF StallD StallE StallM FlushD FlushE FlushM FlushW md_done
  wire [8:0] obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, md_done};

  localparam logic [8:0] V_IDLE = 9'b000000000;
  localparam logic [8:0] V_LW   = 9'b110001000;
  localparam logic [8:0] V_BR   = 9'b000011000;
  localparam logic [8:0] V_MD   = 9'b111000100;
  localparam logic [8:0] V_MEM  = 9'b111100010;
  localparam logic [8:0] V_DONE = 9'b000000001;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_busy;
  int       m_age;
  int       m_wait;
  bit       m_to;
  int       m_scnt;
  int       m_fcnt;
  logic [8:0] exp_v;

  task automatic clear_model();
    m_busy = 0; m_age = 0; m_wait = 0; m_to = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  function automatic logic [8:0] model_out();
    logic mw, lw, rel;
    logic [8:0] v;
    mw  = mem_req_m & ~dmem_ready;
    lw  = ResultSrcE0 && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
    rel = m_busy && (m_age >= MD_LATENCY - 1);
    v   = V_IDLE;
    if (!rst_n)                   v = V_IDLE;
    else if (mw)                  v = V_MEM;
    else if (m_busy && !rel)      v = V_MD;
    else begin
      if (!m_busy && md_start_e)  v = V_MD;
      else if (PCSrcE)            v = V_BR;
      else if (lw)                v = V_LW;
      if (rel)                    v[0] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_update(input logic [8:0] v);
    logic mw;
    mw = mem_req_m & ~dmem_ready;
    if (v[8] && m_scnt < CNT_MAX) m_scnt++;
    if (v[4] && m_fcnt < CNT_MAX) m_fcnt++;
    if (mw) begin
      if (m_wait < MEM_TIMEOUT) m_wait++;
    end else m_wait = 0;
    if (m_wait >= MEM_TIMEOUT) m_to = 1;
    if (m_busy) begin
      if (m_age >= MD_LATENCY - 1 && !mw) m_busy = 0;
      else m_age++;
    end else if (!mw && md_start_e) begin
      m_busy = 1;
      m_age  = 1;
    end
  endtask

  task automatic apply(input logic [4:0] rs1, rs2, rd,
                       input logic ld, pc, md, req, rdy);
    Rs1D = rs1; Rs2D = rs2; RdE = rd;
    ResultSrcE0 = ld; PCSrcE = pc; md_start_e = md;
    mem_req_m = req; dmem_ready = rdy;
    exp_v = model_out();
  endtask

  // Close the current cycle: clock edge, model step, settle.
  task automatic adv();
    exp_v = model_out();
    @(posedge clk);
    if (rst_n) model_update(exp_v);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    apply(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs, V_IDLE);
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout: got %b want 0", mem_timeout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_load_use();
    logic [8:0] want [2];
    want = '{V_LW, V_IDLE};
    for (int i = 0; i < 2; i++) begin
      if (i == 0) apply(5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      else        apply(5'd5, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (obs !== want[i] || obs !== exp_v) begin
        errors++; $display("FAIL load_use[%0d]: got %b want %b model %b", i, obs, want[i], exp_v);
      end
      adv();
    end
  endtask

  task automatic test_branch();
    logic [8:0] want [3];
    want = '{V_IDLE, V_BR, V_LW};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: apply(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        1: apply(5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        default: apply(5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      endcase
      @(negedge clk);
      checks++;
      if (obs !== want[i] || obs !== exp_v) begin
        errors++; $display("FAIL branch[%0d]: got %b want %b model %b", i, obs, want[i], exp_v);
      end
      adv();
    end
  endtask

  task automatic test_muldiv();
    logic [8:0] want [6];
    want = '{V_MD, V_MD, V_MD, V_DONE, V_IDLE, V_BR};
    for (int i = 0; i < 6; i++) begin
      apply(5'd2, 5'd3, 5'd4, 1'b0, (i == 5), (i < 4), 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (obs !== want[i] || obs !== exp_v) begin
        errors++; $display("FAIL muldiv[%0d]: got %b want %b model %b", i, obs, want[i], exp_v);
      end
      adv();
    end
  endtask

  task automatic test_memwait_md();
    logic [8:0] want [8];
    want = '{V_MD, V_MEM, V_MEM, V_MEM, V_MEM, V_MEM, V_DONE, V_IDLE};
    for (int i = 0; i < 8; i++) begin
      apply(5'd2, 5'd3, 5'd4, 1'b0, 1'b0, (i < 7), 1'b1, !(i >= 1 && i <= 5));
      @(negedge clk);
      checks++;
      if (obs !== want[i] || obs !== exp_v) begin
        errors++; $display("FAIL memwait_md[%0d]: got %b want %b model %b", i, obs, want[i], exp_v);
      end
      if (i == 6) md_start_e = 1'b0;
      adv();
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 11; i++) begin
      apply(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, (i >= MEM_TIMEOUT));
      @(negedge clk);
      checks++;
      if (mem_timeout !== (i >= MEM_TIMEOUT) || mem_timeout !== m_to) begin
        errors++; $display("FAIL timeout[%0d]: got %b want %b", i, mem_timeout, (i >= MEM_TIMEOUT));
      end
      adv();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    adv();
  endtask

  task automatic test_reset_mid_md();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      apply(5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (i < 2) adv();
    end
    // Third cycle: the mul/div counter is at 2 and stalls are active.
    @(negedge clk);
    checks++;
    if (obs !== V_MD) begin
      errors++; $display("FAIL rst_md_pre: got %b want %b", obs, V_MD);
    end
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if (obs !== V_IDLE || stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL rst_md_async: got %b cnt %0d/%0d want %b 0/0",
                         obs, stall_cnt, flush_cnt, V_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE || obs !== exp_v) begin
      errors++; $display("FAIL rst_md_after: got %b want %b", obs, V_IDLE);
    end
    adv();
    apply(5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (obs !== V_MD || stall_cnt !== '0) begin
      errors++; $display("FAIL rst_md_restart: got %b cnt %0d want %b 0", obs, stall_cnt, V_MD);
    end
    adv();
    md_start_e = 1'b0;
    repeat (4) adv();
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) != 0));
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, obs, exp_v);
      end
      checks++;
      if (stall_cnt !== CNT_W'(m_scnt) || flush_cnt !== CNT_W'(m_fcnt) || mem_timeout !== m_to) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d/%b want %0d/%0d/%b",
                           i, stall_cnt, flush_cnt, mem_timeout, m_scnt, m_fcnt, m_to);
      end
      adv();
    end
    checks++;
    if (stall_cnt !== CNT_W'(CNT_MAX)) begin
      errors++; $display("FAIL stall_cnt_sat: got %0d want %0d", stall_cnt, CNT_MAX);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    Rs1D = '0; Rs2D = '0; RdE = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; md_start_e = 1'b0;
    mem_req_m = 1'b0; dmem_ready = 1'b1;
    clear_model();
    exp_v = V_IDLE;
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_memwait_md();
    test_timeout();
    test_reset_mid_md();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
